// File: rtl/protocore_pkg.sv
// Shared ProtoCore instruction-format constants: opcodes, field positions, HALT word
// and the per-opcode field-keep table used by both encoder and decoder.
package protocore_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_NOT  = 4'h5;
  localparam logic [3:0] OP_SHL  = 4'h6;
  localparam logic [3:0] OP_SHR  = 4'h7;
  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_LDI  = 4'h9;
  localparam logic [3:0] OP_LD   = 4'hA;
  localparam logic [3:0] OP_ST   = 4'hB;
  localparam logic [3:0] OP_BEQ  = 4'hC;
  localparam logic [3:0] OP_BNE  = 4'hD;
  localparam logic [3:0] OP_JMP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int WORD_W   = 24;
  localparam int OPC_LSB  = 20;
  localparam int RA_LSB   = 16;
  localparam int RB_LSB   = 12;
  localparam int RD_LSB   = 8;
  localparam int DATA_LSB = 0;

  localparam logic [23:0] HALT_WORD = 24'hF00000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCEPT = 3'd1,
    ST_WRITE  = 3'd2,
    ST_PAD    = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } enc_state_e;

  // Returns {keep_ra, keep_rb, keep_rd, keep_data} for an opcode class.
  function automatic logic [3:0] field_keep(input logic [3:0] op);
    logic [3:0] keep;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: keep = 4'b1110;
      OP_NOT, OP_SHL, OP_SHR:                keep = 4'b1010;
      OP_ADDI, OP_LDI, OP_LD:                keep = 4'b1011;
      OP_ST, OP_BEQ, OP_BNE:                 keep = 4'b1101;
      OP_JMP:                                keep = 4'b1001;
      OP_HALT:                               keep = 4'b0000;
      default:                               keep = 4'b0000;
    endcase
    return keep;
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: masks fields unused by the opcode class and concatenates
// them into a canonical 24-bit ProtoCore word.
module instr_pack
  import protocore_pkg::*;
(
  input  logic [3:0]  opcode_i,
  input  logic [3:0]  ra_i,
  input  logic [3:0]  rb_i,
  input  logic [3:0]  rd_i,
  input  logic [7:0]  data_i,
  output logic [23:0] word_o
);

  logic [3:0] keep_s;

  // Apply the opcode-class field mask and assemble the word.
  always_comb begin
    keep_s = field_keep(opcode_i);
    word_o = {opcode_i,
              keep_s[3] ? ra_i   : 4'h0,
              keep_s[2] ? rb_i   : 4'h0,
              keep_s[1] ? rd_i   : 4'h0,
              keep_s[0] ? data_i : 8'h00};
  end

endmodule

// File: rtl/instruction_encoder.sv
// Program loader: accepts field bundles, writes packed words sequentially into
// instruction memory, appends HALT when needed and holds the CPU while loading.
module instruction_encoder
  import protocore_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_opcode,
  input  logic [3:0]        in_ra,
  input  logic [3:0]        in_rb,
  input  logic [3:0]        in_rd,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [23:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W:0]   LAST_PTR = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  enc_state_e        state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [23:0]       wdata_q, wdata_d;
  logic              last_q, last_d;
  logic              in_ready_q, in_ready_d;
  logic              imem_we_q, imem_we_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              done_q, done_d;
  logic              overflow_q, overflow_d;

  logic [23:0]       packed_s;
  logic [ADDR_W-1:0] ptr_s;
  logic              at_end_s;

  instr_pack u_pack (
    .opcode_i (in_opcode),
    .ra_i     (in_ra),
    .rb_i     (in_rb),
    .rd_i     (in_rd),
    .data_i   (in_data),
    .word_o   (packed_s)
  );

  // The write pointer is the low part of the word counter; they advance together.
  assign ptr_s    = cnt_q[ADDR_W-1:0];
  assign at_end_s = (cnt_q == LAST_PTR);

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) state_d = ST_ACCEPT;
        else       state_d = state_q;
      end
      ST_ACCEPT: begin
        if (in_valid) state_d = ST_WRITE;
        else          state_d = ST_ACCEPT;
      end
      ST_WRITE: begin
        if (!last_q)                                  state_d = at_end_s ? ST_ERROR : ST_ACCEPT;
        else if (wdata_q[23:OPC_LSB] == OP_HALT)      state_d = ST_DONE;
        else                                          state_d = at_end_s ? ST_ERROR : ST_PAD;
      end
      ST_PAD:  state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next-state: counter, captured word and write address.
  always_comb begin
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) cnt_d = '0;
        else       cnt_d = cnt_q;
      end
      ST_ACCEPT: begin
        if (in_valid) begin
          addr_d  = ptr_s;
          wdata_d = packed_s;
          last_d  = in_last;
        end else begin
          addr_d  = addr_q;
        end
      end
      ST_WRITE: begin
        cnt_d = cnt_q + CNT_ONE;
        if (state_d == ST_PAD) begin
          addr_d  = ptr_s + ADDR_ONE;
          wdata_d = HALT_WORD;
        end else begin
          addr_d  = addr_q;
        end
      end
      ST_PAD:  cnt_d = cnt_q + CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // FSM outputs, decoded from the next state so they can be registered.
  always_comb begin
    in_ready_d = 1'b0;
    imem_we_d  = 1'b0;
    cpu_hold_d = 1'b0;
    done_d     = 1'b0;
    overflow_d = 1'b0;
    case (state_d)
      ST_IDLE:   cpu_hold_d = 1'b0;
      ST_ACCEPT: begin
        in_ready_d = 1'b1;
        cpu_hold_d = 1'b1;
      end
      ST_WRITE, ST_PAD: begin
        imem_we_d  = 1'b1;
        cpu_hold_d = 1'b1;
      end
      ST_DONE:   done_d = 1'b1;
      // A truncated program must never be released to the CPU.
      ST_ERROR: begin
        overflow_d = 1'b1;
        cpu_hold_d = 1'b1;
      end
      default:   cpu_hold_d = 1'b0;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= 24'h000000;
      last_q     <= 1'b0;
      in_ready_q <= 1'b0;
      imem_we_q  <= 1'b0;
      cpu_hold_q <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      last_q     <= last_d;
      in_ready_q <= in_ready_d;
      imem_we_q  <= imem_we_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_hold   = cpu_hold_q;
  assign done       = done_q;
  assign overflow   = overflow_q;
  assign word_count = cnt_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Scoreboard bench for instruction_encoder with a 4-word memory so that the
// overflow and pad-overflow boundaries are reachable.
module tb_instruction_encoder;

  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n, start, in_valid, in_last;
  logic [3:0]    in_opcode, in_ra, in_rb, in_rd;
  logic [7:0]    in_data;
  logic          in_ready, imem_we, cpu_hold, done, overflow;
  logic [AW-1:0] imem_addr;
  logic [23:0]   imem_wdata;
  logic [AW:0]   word_count;

  always #5 clk = ~clk;

  instruction_encoder #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_ra(in_ra), .in_rb(in_rb), .in_rd(in_rd), .in_data(in_data),
    .in_last(in_last), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .done(done), .overflow(overflow), .word_count(word_count)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [23:0]   data;
  } wr_t;

  wr_t sb_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  exp_ptr  = 0;

  // Reference word: bit mask per opcode class, opcode always kept.
  function automatic logic [23:0] ref_word(input logic [3:0] op, input logic [3:0] ra,
                                           input logic [3:0] rb, input logic [3:0] rd,
                                           input logic [7:0] data);
    logic [23:0] mask;
    case (op)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4: mask = 24'h0FFF00;
      4'h5, 4'h6, 4'h7:             mask = 24'h0F0F00;
      4'h8, 4'h9, 4'hA:             mask = 24'h0F0FFF;
      4'hB, 4'hC, 4'hD:             mask = 24'h0FF0FF;
      4'hE:                         mask = 24'h0F00FF;
      default:                      mask = 24'h000000;
    endcase
    return ({op, ra, rb, rd, data} & mask) | {op, 20'h00000};
  endfunction

  task automatic expect_transfer(input logic [3:0] op, input logic [3:0] ra, input logic [3:0] rb,
                                 input logic [3:0] rd, input logic [7:0] data, input logic last);
    wr_t w;
    w.addr = exp_ptr[AW-1:0];
    w.data = ref_word(op, ra, rb, rd, data);
    sb_q.push_back(w);
    exp_ptr++;
    if (last && op != 4'hF && exp_ptr < DEPTH) begin
      w.addr = exp_ptr[AW-1:0];
      w.data = 24'hF00000;
      sb_q.push_back(w);
      exp_ptr++;
    end
  endtask

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n === 1'b1 && imem_we === 1'b1) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: addr=%0h data=%06h, required no write", imem_addr, imem_wdata);
      end else begin
        e = sb_q.pop_front();
        if (imem_addr !== e.addr || imem_wdata !== e.data) begin
          n_fail++;
          $display("FAIL write: got addr=%0h data=%06h, required addr=%0h data=%06h",
                   imem_addr, imem_wdata, e.addr, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_ptr = 0;
  endtask

  task automatic send(input logic [3:0] op, input logic [3:0] ra, input logic [3:0] rb,
                      input logic [3:0] rd, input logic [7:0] data, input logic last);
    bit got = 1'b0;
    in_opcode = op; in_ra = ra; in_rb = rb; in_rd = rd; in_data = data; in_last = last;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) got = 1'b1;
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL send_timeout: got in_ready=0 for 20 cycles, required 1");
    end else begin
      expect_transfer(op, ra, rb, rd, data, last);
    end
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) tick();
    repeat (2) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_opcode = 4'h0; in_ra = 4'h0; in_rb = 4'h0; in_rd = 4'h0; in_data = 8'h00;
    #12;
    n_checks++;
    if ({in_ready, imem_we, cpu_hold, done, overflow} !== 5'b00000) begin
      n_fail++; $display("FAIL reset_flags: got %05b, required 00000", {in_ready, imem_we, cpu_hold, done, overflow});
    end
    n_checks++;
    if (word_count !== 3'd0 || imem_addr !== 2'd0 || imem_wdata !== 24'h0) begin
      n_fail++; $display("FAIL reset_data: got wc=%0d addr=%0h wdata=%06h, required 0", word_count, imem_addr, imem_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_masking();
    do_start();
    n_checks++;
    if (cpu_hold !== 1'b1 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL start_accept: got hold=%b ready=%b, required 1 1", cpu_hold, in_ready);
    end
    send(4'h0, 4'h2, 4'h3, 4'h1, 8'h55, 1'b1);
    drain();
    n_checks++;
    if (sb_q.size() != 0) begin n_fail++; $display("FAIL mask_writes: got %0d pending, required 0", sb_q.size()); end
    n_checks++;
    if (done !== 1'b1 || cpu_hold !== 1'b0 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL mask_status: got done=%b hold=%b ovf=%b, required 1 0 0", done, cpu_hold, overflow);
    end
    n_checks++;
    if (word_count !== 3'd2) begin n_fail++; $display("FAIL mask_count: got %0d, required 2", word_count); end
  endtask

  task automatic test_jump_branch();
    do_start();
    send(4'hE, 4'h4, 4'h5, 4'h6, 8'h10, 1'b0);
    send(4'hC, 4'h1, 4'h2, 4'h7, 8'h20, 1'b0);
    send(4'hF, 4'h3, 4'h3, 4'h3, 8'hAA, 1'b1);
    drain();
    n_checks++;
    if (sb_q.size() != 0) begin n_fail++; $display("FAIL jb_writes: got %0d pending, required 0", sb_q.size()); end
    n_checks++;
    if (word_count !== 3'd3 || done !== 1'b1) begin
      n_fail++; $display("FAIL jb_status: got wc=%0d done=%b, required 3 1", word_count, done);
    end
  endtask

  task automatic test_random_words();
    logic [3:0] op, ra, rb, rd;
    logic [7:0] data;
    for (int r = 0; r < 4; r++) begin
      do_start();
      for (int k = 0; k < 3; k++) begin
        op = 4'($urandom_range(15, 0)); ra = 4'($urandom_range(15, 0));
        rb = 4'($urandom_range(15, 0)); rd = 4'($urandom_range(15, 0));
        data = 8'($urandom_range(255, 0));
        send(op, ra, rb, rd, data, k == 2);
      end
      drain();
      n_checks++;
      if (word_count !== 3'(exp_ptr) || done !== 1'b1 || sb_q.size() != 0) begin
        n_fail++; $display("FAIL rand_load: got wc=%0d done=%b pending=%0d, required wc=%0d done=1 pending=0",
                           word_count, done, sb_q.size(), exp_ptr);
      end
    end
  endtask

  task automatic test_backpressure();
    do_start();
    for (int i = 0; i < 6; i++) begin
      in_opcode = 4'h8; in_ra = 4'(i); in_rb = 4'hF; in_rd = 4'(15 - i);
      in_data = 8'(8'h30 + i); in_last = (i == 4); in_valid = 1'b1;
      @(negedge clk);
      n_checks++;
      if (in_ready !== ((i % 2) == 0)) begin
        n_fail++; $display("FAIL bp_ready[%0d]: got %b, required %b", i, in_ready, (i % 2) == 0);
      end
      if (in_ready === 1'b1) expect_transfer(in_opcode, in_ra, in_rb, in_rd, in_data, in_last);
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0;
    drain();
    n_checks++;
    if (word_count !== 3'd4 || done !== 1'b1 || sb_q.size() != 0) begin
      n_fail++; $display("FAIL bp_status: got wc=%0d done=%b pending=%0d, required 4 1 0", word_count, done, sb_q.size());
    end
  endtask

  task automatic test_overflow();
    do_start();
    for (int k = 0; k < 4; k++) send(4'h1, 4'(k), 4'h9, 4'h6, 8'hC3, 1'b0);
    in_valid = 1'b1; in_opcode = 4'h2;
    drain();
    n_checks++;
    if (overflow !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL ovf_status: got ovf=%b done=%b hold=%b ready=%b, required 1 0 1 0",
                         overflow, done, cpu_hold, in_ready);
    end
    n_checks++;
    if (word_count !== 3'd4 || sb_q.size() != 0) begin
      n_fail++; $display("FAIL ovf_count: got wc=%0d pending=%0d, required 4 0", word_count, sb_q.size());
    end
    in_valid = 1'b0;
    do_start();
    n_checks++;
    if (overflow !== 1'b0 || in_ready !== 1'b1 || word_count !== 3'd0) begin
      n_fail++; $display("FAIL ovf_restart: got ovf=%b ready=%b wc=%0d, required 0 1 0", overflow, in_ready, word_count);
    end
    send(4'hF, 4'h0, 4'h0, 4'h0, 8'h00, 1'b1);
    drain();
  endtask

  task automatic test_pad_overflow();
    do_start();
    for (int k = 0; k < 3; k++) send(4'h2, 4'(k), 4'h1, 4'h2, 8'h11, 1'b0);
    send(4'h3, 4'h7, 4'h8, 4'h9, 8'h22, 1'b1);
    drain();
    n_checks++;
    if (overflow !== 1'b1 || done !== 1'b0 || word_count !== 3'd4 || sb_q.size() != 0) begin
      n_fail++; $display("FAIL pad_ovf: got ovf=%b done=%b wc=%0d pending=%0d, required 1 0 4 0",
                         overflow, done, word_count, sb_q.size());
    end
  endtask

  task automatic test_start_ignored();
    do_start();
    send(4'h1, 4'h1, 4'h2, 4'h3, 8'h44, 1'b0);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (word_count !== 3'd1 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL start_ignored: got wc=%0d ready=%b, required 1 1", word_count, in_ready);
    end
    send(4'hF, 4'h0, 4'h0, 4'h0, 8'h00, 1'b1);
    drain();
    n_checks++;
    if (word_count !== 3'd2 || done !== 1'b1 || sb_q.size() != 0) begin
      n_fail++; $display("FAIL start_ignored_end: got wc=%0d done=%b, required 2 1", word_count, done);
    end
  endtask

  task automatic test_reset_mid();
    do_start();
    in_opcode = 4'h1; in_ra = 4'h5; in_rb = 4'h5; in_rd = 4'h5; in_data = 8'h00;
    in_last = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (imem_we !== 1'b1 || cpu_hold !== 1'b1) begin
      n_fail++; $display("FAIL mid_write: got we=%b hold=%b, required 1 1", imem_we, cpu_hold);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, imem_we, cpu_hold, done, overflow} !== 5'b00000 || word_count !== 3'd0) begin
      n_fail++; $display("FAIL mid_reset: got flags=%05b wc=%0d, required 00000 0",
                         {in_ready, imem_we, cpu_hold, done, overflow}, word_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_masking();
    test_jump_branch();
    test_random_words();
    test_backpressure();
    test_overflow();
    test_pad_overflow();
    test_start_ignored();
    test_reset_mid();
    n_checks++;
    if (sb_q.size() != 0) begin n_fail++; $display("FAIL final_pending: got %0d, required 0", sb_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
